// File: rtl/arbiter_rr_8_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_8_if
// Description : Request/grant bundle between eight requesters, their shared
//               consumer and the round-robin arbiter.
//                 req     [7:0] per-requester request lines
//                 ack           consumer acknowledge, completes the grant
//                 gnt_idx [2:0] binary index of granted requester
//                 gnt_vld       gnt_idx valid, grant held while high
//                 to_err        one-cycle pulse on grant timeout
//               master : requester/consumer side (drives req, ack)
//               slave  : arbiter side (drives gnt_idx, gnt_vld, to_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_rr_8_if;
    logic [7:0] req;
    logic       ack;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       to_err;

    modport master (
        output req,
        output ack,
        input  gnt_idx,
        input  gnt_vld,
        input  to_err
    );

    modport slave (
        input  req,
        input  ack,
        output gnt_idx,
        output gnt_vld,
        output to_err
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_rr_8.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_8
// Description : 8-way round-robin arbiter with registered binary grant.
//               A rotating pointer sets the search start; after each
//               completed grant the pointer moves one past the winner, so
//               the just-served requester has lowest priority next time.
//               Back-to-back grants are issued on the ack edge.
// Ports       : clk       single clock, rising edge
//               rst       synchronous active-low reset
//               bus       arbiter_rr_8_if.slave (req, ack, gnt_idx,
//                         gnt_vld, to_err)
// Parameters  : TO_CYCLES grant-timeout length in cycles (2..255)
// Options     : ARB_TIMEOUT_EN  compiles in the grant watchdog; when
//               undefined to_err is tied low and grants last until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_8 #(
    parameter int TO_CYCLES = 16
) (
    input  wire               clk,
    input  wire               rst,
    arbiter_rr_8_if.slave     bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_vld;

    logic       w_any;
    logic [2:0] w_base;
    logic [2:0] w_cand;
    logic [2:0] w_win;
    logic       w_found;
    logic       w_timeout;
    logic       w_release;

    generate
        if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to_cycles
            $error("arbiter_rr_8: TO_CYCLES out of range 2..255");
        end
    endgenerate

    // While granting, the search base is the pointer value that the
    // release edge will install (gnt_idx+1), so a back-to-back winner is
    // chosen from the updated pointer in the same cycle.
    always_comb begin
        w_any   = |bus.req;
        w_base  = (r_state == S_GRANT) ? (r_gnt_idx + 3'd1) : r_ptr;
        w_win   = w_base;
        w_cand  = w_base;
        w_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_cand = w_base + 3'(i);
            if (!w_found && bus.req[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_to_err;

    // r_cnt counts completed GRANT cycles without ack; the edge that would
    // make it reach TO_CYCLES releases the grant instead.
    assign w_timeout = (r_state == S_GRANT) && !bus.ack
                       && (r_cnt == 8'(TO_CYCLES - 1));
    assign bus.to_err = r_to_err;
`else
    assign w_timeout  = 1'b0;
    assign bus.to_err = 1'b0;
`endif

    assign w_release = bus.ack || w_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_gnt_idx <= 3'd0;
            r_gnt_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= 8'd0;
            r_to_err  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_to_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // ack is ignored here; gnt_idx keeps its last value.
                    if (w_any) begin
                        r_gnt_idx <= w_win;
                        r_gnt_vld <= 1'b1;
                        r_state   <= S_GRANT;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= 8'd0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_gnt_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                        r_cnt    <= 8'd0;
                        r_to_err <= w_timeout;
`endif
                        if (w_any) begin
                            r_gnt_idx <= w_win;
                        end else begin
                            r_gnt_vld <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        r_cnt <= r_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_vld = r_gnt_vld;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_rr_8
// Description : Self-checking bench for arbiter_rr_8. A table of directed
//               {rst, req, ack -> gnt_vld, gnt_idx, to_err} rows is applied
//               one clock per row, followed by a hand-written grant-timeout
//               sequence whose expectations depend on ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr_8;

    localparam int C_TO_CYCLES = 16;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       exp_vld;
        logic [2:0] exp_idx;
        logic       exp_err;
    } vec_t;

    logic clk;
    logic rst;
    arbiter_rr_8_if bus ();

    arbiter_rr_8 #(.TO_CYCLES(C_TO_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs [64];
    int   n_vecs   = 0;

    task automatic add(input logic r, input logic [7:0] rq, input logic a,
                       input logic v, input logic [2:0] ix);
        vecs[n_vecs] = '{rst: r, req: rq, ack: a, exp_vld: v,
                         exp_idx: ix, exp_err: 1'b0};
        n_vecs++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic a);
        rst     = r;
        bus.req = rq;
        bus.ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic [2:0] ix, input logic e);
        check({tag, ".gnt_vld"}, int'(bus.gnt_vld), int'(v));
        check({tag, ".gnt_idx"}, int'(bus.gnt_idx), int'(ix));
        check({tag, ".to_err"},  int'(bus.to_err),  int'(e));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        bus.req = 8'h00;
        bus.ack = 1'b0;

        // Reset held two cycles with all requesting, then release.
        add(0, 8'hFF, 0, 0, 3'd0);
        add(0, 8'hFF, 0, 0, 3'd0);
        add(1, 8'hFF, 0, 1, 3'd0);
        // Full rotation with ack every cycle, no idle gaps.
        for (int k = 1; k <= 8; k++) add(1, 8'hFF, 1, 1, 3'(k));
        // Continue to grant 5, then release with no requests -> ptr=6.
        for (int k = 1; k <= 5; k++) add(1, 8'hFF, 1, 1, 3'(k));
        add(1, 8'h00, 1, 0, 3'd5);
        // ptr=6, req=0000_0101: wrap to 0, then 2, then 0.
        add(1, 8'h05, 0, 1, 3'd0);
        add(1, 8'h05, 1, 1, 3'd2);
        add(1, 8'h05, 1, 1, 3'd0);
        add(1, 8'h00, 1, 0, 3'd0);
        // ack while idle is ignored.
        add(1, 8'h00, 1, 0, 3'd0);
        add(1, 8'h00, 1, 0, 3'd0);
        // Grant 3, drop its request, hold ack low 5 cycles.
        add(1, 8'h08, 0, 1, 3'd3);
        for (int k = 0; k < 5; k++) add(1, 8'h00, 0, 1, 3'd3);
        add(1, 8'h00, 1, 0, 3'd3);
        // ptr=4, grant 0, reset mid-grant with ack low, then req[7].
        add(1, 8'h01, 0, 1, 3'd0);
        add(0, 8'h01, 0, 0, 3'd0);
        add(1, 8'h80, 0, 1, 3'd7);
        // Single requester regranted on every ack.
        add(1, 8'h80, 1, 1, 3'd7);
        add(1, 8'h80, 1, 1, 3'd7);
        // Just-acked requester drops to lowest priority.
        add(1, 8'h81, 1, 1, 3'd0);
        add(1, 8'h81, 1, 1, 3'd7);
        add(1, 8'h00, 1, 0, 3'd7);

        for (int i = 0; i < n_vecs; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].ack);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_vld,
                       vecs[i].exp_idx, vecs[i].exp_err);
        end

        // Grant-timeout sequence from a fresh reset, req=8'h03, ack low.
        step(0, 8'h03, 0);
        expect_out("to_rst", 1'b0, 3'd0, 1'b0);
        for (int c = 0; c < C_TO_CYCLES; c++) begin
            step(1, 8'h03, 0);
            expect_out($sformatf("to_hold%0d", c), 1'b1, 3'd0, 1'b0);
        end
`ifdef ARB_TIMEOUT_EN
        step(1, 8'h03, 0);
        expect_out("to_fire", 1'b1, 3'd1, 1'b1);
        step(1, 8'h03, 0);
        expect_out("to_after", 1'b1, 3'd1, 1'b0);
        // ack on the timeout edge wins: no to_err pulse.
        for (int c = 0; c < C_TO_CYCLES - 2; c++) step(1, 8'h03, 0);
        step(1, 8'h03, 1);
        expect_out("to_ack_wins", 1'b1, 3'd0, 1'b0);
`else
        for (int c = 0; c < 4; c++) begin
            step(1, 8'h03, 0);
            expect_out($sformatf("no_to%0d", c), 1'b1, 3'd0, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
